count_sequencer: RTL and testbench
==================================

// Module: count_sequencer
// PURPOSE
//  Controller that sequences one 74163-style 4-bit counter (ENP/ENT/LDb/CLRb/RCO).
//  Turns debounced button commands into one-cycle synchronous control pulses.
//  Owns the prescaler that paces counting, e.g. one count per half second at 50 MHz.
//  Sits between the debouncers and the counter; both blocks are clocked by CLK50M.
// PARAMETERS
//  TICK_DIV  25_000_000  CLK50M cycles per count step (>=2)
//  PRE_W     25          prescaler width; must satisfy 2**PRE_W >= TICK_DIV
// PORTS
//  CLK50M   in   1  system clock; the only clock in the block
//  RSTb     in   1  asynchronous, active-low reset
//  START    in   1  debounced level; rising edge starts or resumes counting
//  STOP     in   1  debounced level; rising edge pauses counting
//  CLR_REQ  in   1  debounced level; rising edge clears the counter
//  LD_REQ   in   1  debounced level; rising edge loads LD_VAL into the counter
//  LD_VAL   in   4  load value, captured on the LD_REQ edge
//  ONESHOT  in   1  level; 1 = stop at terminal count instead of wrapping
//  RCO      in   1  ripple carry from the counter (ENT & Q==4'hF)
//  ENP      out  1  counter count-enable; one-cycle pulse per step
//  ENT      out  1  counter carry-enable
//  LDb      out  1  counter synchronous load, active-low; one-cycle pulse
//  CLRb     out  1  counter synchronous clear, active-low; one-cycle pulse
//  D        out  4  counter load data
//  TICK     out  1  prescaler terminal pulse, driven only in RUN
//  STATE    out  3  current state encoding, for debug LEDs
//  DONE     out  1  1 while in state DONE
// BEHAVIOUR
//  Reset values: ENP=0, ENT=1, LDb=1, CLRb=1, D=0, TICK=0, DONE=0,
//   STATE=IDLE, prescaler=0.
//  Edge detect: each button is registered once. Edge = cur & ~prev.
//   All prev registers reset to 1, so a button held at reset gives no edge.
//  Command latency: edge on input in cycle n -> state change at edge n+2.
//   The control pulse (CLRb/LDb low) is present during the CLEAR/LOAD state cycle.
//  Simultaneous edges in one cycle: CLR > LD > STOP > START.
//   Only the winning edge acts; the others are discarded.
//  States (STATE): IDLE=0, RUN=1, PAUSE=2, CLEAR=3, LOAD=4, DONE=5.
//   IDLE : START->RUN; STOP ignored.
//   RUN  : prescaler counts each cycle. At TICK_DIV-1 it wraps to 0 and pulses TICK.
//          On that TICK, ENP=1 for exactly that cycle.
//          Exception: ONESHOT=1 with RCO=1 at the TICK -> no ENP; go to DONE.
//          STOP->PAUSE.
//   PAUSE: prescaler frozen (not cleared); START->RUN resumes from the frozen value.
//   CLEAR: one cycle; CLRb=0 and prescaler<=0.
//          Next state is RUN if entered from RUN, otherwise IDLE.
//   LOAD : one cycle; LDb=0 and D holds LD_VAL captured at the edge.
//          Next state is RUN if entered from RUN, otherwise IDLE.
//          Prescaler is untouched.
//   DONE : ENT=0, so RCO drops; START and STOP ignored.
//          CLR->CLEAR->IDLE; LD->LOAD->IDLE.
//   CLR_REQ and LD_REQ are accepted from every state.
//  Output rules:
//   ENT=1 in every state except DONE.
//   ENP is never 1 in the same cycle as LDb=0 or CLRb=0.
//   A command pre-empts a TICK that falls in the same cycle: that step is lost.
//   ONESHOT is sampled only at TICK; changing it mid-run has no other effect.
//  Reset mid-operation: all state returns to reset values immediately (async).
//   Any pending edge is discarded.
//  D holds its last loaded value until the next LD edge.
//  Unused state encodings (6, 7) recover to IDLE on the next clock.
// TESTING (TICK_DIV=4 in simulation)
//  Reset with START held high, release RSTb -> no edge; STATE stays 0, ENP never 1.
//  START pulse -> STATE=1 at 2 clk; ENP pulses every 4 clk; 16 steps wrap Q 15->0.
//  LD_VAL=4'hD, LD_REQ edge in RUN -> LDb=0 for 1 clk, D=4'hD, back to RUN, no ENP that cycle.
//  ONESHOT=1 with Q=4'hE -> one more step to 4'hF; next TICK gives no ENP, DONE=1, ENT=0.
//  CLR_REQ and STOP edges in the same cycle during RUN -> CLRb=0 for 1 clk; state returns RUN.
//  STOP at prescaler=2, then START -> first ENP after 2 more clk; RSTb low mid-RUN -> all outputs at reset values.

Source files
------------

// File: rtl/count_sequencer.sv
// count_sequencer
//   Controller for one 74163-style 4-bit counter. Debounced button levels are
//   turned into one-cycle synchronous control pulses, and an internal prescaler
//   paces the count steps (one step every TICK_DIV clocks while running).
//
// Ports
//   CLK50M   in   system clock (only clock of the block)
//   RSTb     in   asynchronous active-low reset
//   START    in   rising edge starts/resumes counting
//   STOP     in   rising edge pauses counting
//   CLR_REQ  in   rising edge clears the counter
//   LD_REQ   in   rising edge loads LD_VAL into the counter
//   LD_VAL   in   [3:0] load value, captured when the load is accepted
//   ONESHOT  in   1 = stop at terminal count instead of wrapping
//   RCO      in   ripple carry from the counter
//   ENP      out  count enable, one-cycle pulse per step
//   ENT      out  carry enable, low only in DONE
//   LDb      out  synchronous load, active-low pulse
//   CLRb     out  synchronous clear, active-low pulse
//   D        out  [3:0] counter load data
//   TICK     out  prescaler terminal pulse, only in RUN
//   STATE    out  [2:0] current state, for debug LEDs
//   DONE     out  high while in DONE
module count_sequencer #(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned PRE_W    = 25
) (
    input  logic       CLK50M,
    input  logic       RSTb,
    input  logic       START,
    input  logic       STOP,
    input  logic       CLR_REQ,
    input  logic       LD_REQ,
    input  logic [3:0] LD_VAL,
    input  logic       ONESHOT,
    input  logic       RCO,
    output logic       ENP,
    output logic       ENT,
    output logic       LDb,
    output logic       CLRb,
    output logic [3:0] D,
    output logic       TICK,
    output logic [2:0] STATE,
    output logic       DONE
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_CLEAR = 3'd3;
    localparam logic [2:0] ST_LOAD  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // Button bit order: [0]=START [1]=STOP [2]=CLR_REQ [3]=LD_REQ
    logic [3:0]       btn_cur_q, btn_prev_q;
    logic [3:0]       edges;
    logic [2:0]       state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             ret_run_q, ret_run_d;
    logic [3:0]       d_q, d_d;
    logic             tick, enp, from_run;

    // Both stages reset high so a button already held at reset makes no edge.
    assign edges = btn_cur_q & ~btn_prev_q;

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        ret_run_d = ret_run_q;
        d_d       = d_q;
        tick      = 1'b0;
        enp       = 1'b0;
        // A command issued from CLEAR/LOAD keeps the original return target.
        from_run  = (state_q == ST_RUN) ||
                    (((state_q == ST_CLEAR) || (state_q == ST_LOAD)) && ret_run_q);

        case (state_q)
            ST_IDLE, ST_PAUSE: begin
                if (edges[0]) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                tick  = (pre_q == PRE_LAST);
                pre_d = tick ? '0 : pre_q + PRE_W'(1);
                if (edges[1]) begin
                    state_d = ST_PAUSE;
                end else if (tick && ONESHOT && RCO) begin
                    state_d = ST_DONE;
                end
                // Any accepted command in this cycle swallows the step.
                enp = tick && (edges[3:1] == 3'b000) && !(ONESHOT && RCO);
            end
            ST_CLEAR: begin
                pre_d   = '0;
                state_d = ret_run_q ? ST_RUN : ST_IDLE;
            end
            ST_LOAD: begin
                state_d = ret_run_q ? ST_RUN : ST_IDLE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear and load are accepted everywhere and outrank STOP/START.
        if (edges[2]) begin
            state_d   = ST_CLEAR;
            ret_run_d = from_run;
        end else if (edges[3]) begin
            state_d   = ST_LOAD;
            ret_run_d = from_run;
            d_d       = LD_VAL;
        end
    end

    always_ff @(posedge CLK50M or negedge RSTb) begin
        if (!RSTb) begin
            btn_cur_q  <= 4'hF;
            btn_prev_q <= 4'hF;
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            ret_run_q  <= 1'b0;
            d_q        <= 4'h0;
        end else begin
            btn_cur_q  <= {LD_REQ, CLR_REQ, STOP, START};
            btn_prev_q <= btn_cur_q;
            state_q    <= state_d;
            pre_q      <= pre_d;
            ret_run_q  <= ret_run_d;
            d_q        <= d_d;
        end
    end

    assign ENP   = enp;
    assign TICK  = tick;
    assign ENT   = (state_q != ST_DONE);
    assign LDb   = (state_q != ST_LOAD);
    assign CLRb  = (state_q != ST_CLEAR);
    assign D     = d_q;
    assign STATE = state_q;
    assign DONE  = (state_q == ST_DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer with TICK_DIV=4. A 74163-like counter is attached
// to the control outputs and drives RCO back. A behavioural model predicts all
// outputs every cycle; directed steps add literal expectations.
module tb_count_sequencer;

    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       rstb, start, stop, clr_req, ld_req, oneshot, rco;
    logic [3:0] ld_val;
    logic       enp, ent, ldb, clrb, tick, done;
    logic [3:0] d;
    logic [2:0] state;
    logic [3:0] dq = 4'h0;

    int checks = 0;
    int errors = 0;

    count_sequencer #(.TICK_DIV(TDIV), .PRE_W(2)) dut (
        .CLK50M (clk),
        .RSTb   (rstb),
        .START  (start),
        .STOP   (stop),
        .CLR_REQ(clr_req),
        .LD_REQ (ld_req),
        .LD_VAL (ld_val),
        .ONESHOT(oneshot),
        .RCO    (rco),
        .ENP    (enp),
        .ENT    (ent),
        .LDb    (ldb),
        .CLRb   (clrb),
        .D      (d),
        .TICK   (tick),
        .STATE  (state),
        .DONE   (done)
    );

    always #5 clk = ~clk;

    // External 74163-style counter driven by the DUT.
    assign rco = ent && (dq == 4'hF);
    always @(posedge clk) begin
        if (!clrb)            dq <= 4'h0;
        else if (!ldb)        dq <= d;
        else if (enp && ent)  dq <= dq + 4'h1;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural model: states 0..5 as in the debug encoding.
    int         m_st, m_pre, m_q, nst;
    bit         m_ret, from_run;
    logic [3:0] m_d, m_cur, m_prev, ev;
    logic       x_ent, x_rco, x_tick, x_enp, x_ldb, x_clrb, x_done;

    initial begin
        m_q = 0;
        forever begin
            @(negedge clk);
            if (!rstb) begin
                m_st = 0; m_pre = 0; m_ret = 0; m_d = 4'h0;
                m_cur = 4'hF; m_prev = 4'hF;
            end
            ev     = m_cur & ~m_prev;
            x_ent  = (m_st != 5);
            x_rco  = x_ent && (m_q == 15);
            x_tick = (m_st == 1) && (m_pre == TDIV - 1);
            x_enp  = x_tick && (ev[3:1] == 3'b000) && !(oneshot && x_rco);
            x_ldb  = (m_st != 4);
            x_clrb = (m_st != 3);
            x_done = (m_st == 5);
            check("outputs", {3'b0, enp, ent, ldb, clrb, d, tick, state, done},
                  {3'b0, x_enp, x_ent, x_ldb, x_clrb, m_d, x_tick, m_st[2:0], x_done});
            check("counter_q", {12'h0, dq}, {12'h0, m_q[3:0]});
            if (rstb) begin
                if (!x_clrb)              m_q = 0;
                else if (!x_ldb)          m_q = m_d;
                else if (x_enp && x_ent)  m_q = (m_q + 1) % 16;
                from_run = (m_st == 1) || ((m_st == 3 || m_st == 4) && m_ret);
                case (m_st)
                    0, 2:    nst = ev[0] ? 1 : m_st;
                    1:       nst = ev[1] ? 2 : ((x_tick && oneshot && x_rco) ? 5 : 1);
                    3, 4:    nst = m_ret ? 1 : 0;
                    5:       nst = 5;
                    default: nst = 0;
                endcase
                if (m_st == 1) m_pre = (m_pre + 1) % TDIV;
                if (m_st == 3) m_pre = 0;
                if (ev[2]) begin
                    nst = 3; m_ret = from_run;
                end else if (ev[3]) begin
                    nst = 4; m_ret = from_run; m_d = ld_val;
                end
                m_st   = nst;
                m_prev = m_cur;
                m_cur  = {ld_req, clr_req, stop, start};
            end
        end
    end

    initial begin
        rstb = 1'b0; start = 1'b1; stop = 1'b0; clr_req = 1'b0; ld_req = 1'b0;
        ld_val = 4'h0; oneshot = 1'b0;
        step(3);
        check("reset_outs", {9'h0, enp, ent, ldb, clrb, tick, done, 1'b0},
              {9'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        check("reset_state", {13'h0, state}, 16'h0);
        // Held START across reset release makes no edge.
        rstb = 1'b1;
        step(6);
        check("held_start_idle", {13'h0, state}, 16'h0);
        start = 1'b0;
        step(2);

        // START edge -> RUN two clocks later.
        start = 1'b1;
        step(1);
        check("start_lat1", {13'h0, state}, 16'h0);
        step(1);
        check("start_lat2", {13'h0, state}, 16'h1);
        start = 1'b0;
        step(60);
        check("q_after_15", {12'h0, dq}, 16'hF);
        step(4);
        check("q_wrap", {12'h0, dq}, 16'h0);

        // Load in RUN.
        ld_val = 4'hD; ld_req = 1'b1;
        step(2);
        check("load_state", {13'h0, state}, 16'h4);
        check("load_pulse", {14'h0, ldb, enp}, 16'h0);
        check("load_d", {12'h0, d}, 16'hD);
        ld_req = 1'b0;
        step(1);
        check("load_back_run", {13'h0, state}, 16'h1);
        check("load_q", {12'h0, dq}, 16'hD);

        // One-shot: runs up to F, next tick goes DONE without a step.
        oneshot = 1'b1;
        for (int i = 0; i < 40 && !done; i++) step(1);
        check("oneshot_done", {15'h0, done}, 16'h1);
        check("oneshot_ent", {15'h0, ent}, 16'h0);
        check("oneshot_q", {12'h0, dq}, 16'hF);
        step(6);
        check("done_holds", {13'h0, state}, 16'h5);
        oneshot = 1'b0;

        // Clear from DONE returns to IDLE.
        clr_req = 1'b1;
        step(2);
        check("clr_state", {13'h0, state}, 16'h3);
        check("clr_pulse", {15'h0, clrb}, 16'h0);
        clr_req = 1'b0;
        step(1);
        check("clr_to_idle", {13'h0, state}, 16'h0);
        check("clr_q", {12'h0, dq}, 16'h0);

        // Simultaneous CLR and STOP in RUN: clear wins, back to RUN.
        start = 1'b1; step(2); start = 1'b0;
        step(5);
        clr_req = 1'b1; stop = 1'b1;
        step(2);
        check("clr_stop_state", {13'h0, state}, 16'h3);
        clr_req = 1'b0; stop = 1'b0;
        step(1);
        check("clr_stop_run", {13'h0, state}, 16'h1);

        // Pause / resume with frozen prescaler.
        step(1);
        stop = 1'b1; step(2); stop = 1'b0;
        check("pause_state", {13'h0, state}, 16'h2);
        step(4);
        start = 1'b1; step(2); start = 1'b0;
        check("resume_state", {13'h0, state}, 16'h1);
        step(12);

        // Load from PAUSE returns to IDLE.
        stop = 1'b1; step(2); stop = 1'b0;
        ld_val = 4'h3; ld_req = 1'b1;
        step(2);
        check("pause_load", {12'h0, d}, 16'h3);
        ld_req = 1'b0;
        step(1);
        check("pause_load_idle", {13'h0, state}, 16'h0);
        start = 1'b1; step(2); start = 1'b0;
        step(10);

        // Asynchronous reset mid-RUN.
        rstb = 1'b0;
        #1;
        check("async_reset", {3'h0, enp, ent, ldb, clrb, d, tick, state, done},
              {3'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 3'h0, 1'b0});
        step(2);
        rstb = 1'b1;
        step(4);
        check("post_reset_idle", {13'h0, state}, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
